// File: rtl/ant_pkg.sv
// Shared encodings for the ant maze world: move commands, headings and arena FSM states.
package ant_pkg;

    typedef enum logic [1:0] {
        MV_HALT    = 2'b00,
        MV_RIGHT   = 2'b01,
        MV_LEFT    = 2'b10,
        MV_FORWARD = 2'b11
    } move_e;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE,
        ST_TMO
    } state_e;

    localparam int PH_WIDTH_DEF = 2;

endpackage

// File: rtl/ant_ph_map.sv
// Pheromone array: one saturating counter per cell, written and read at the ant's current cell.
module ant_ph_map #(
    parameter int CELLS = 64,
    parameter int AW    = 6,
    parameter int PW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [PW-1:0] i_drop,
    output logic [PW-1:0] o_level
);

    logic [PW-1:0] r_mem [CELLS];
    logic [PW:0]   w_sum;

    // One extra bit catches the carry so the level clamps at all-ones.
    assign w_sum   = {1'b0, r_mem[i_addr]} + {1'b0, i_drop};
    assign o_level = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            for (int i = 0; i < CELLS; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_addr] <= w_sum[PW] ? '1 : w_sum[PW-1:0];
        end
    end

endmodule

// File: rtl/ant_arena.sv
// Maze-world model around the ant controller: pose tracking, wall sensing, pheromone map and run FSM.
module ant_arena
    import ant_pkg::*;
#(
    parameter int                       GRID_W    = 8,
    parameter int                       GRID_H    = 8,
    parameter logic [GRID_W*GRID_H-1:0] MAZE      = '0,
    parameter int                       START_X   = 0,
    parameter int                       START_Y   = 0,
    parameter int                       START_DIR = 1,
    parameter int                       EXIT_X    = 7,
    parameter int                       EXIT_Y    = 7,
    parameter int                       MAX_STEPS = 1023,
    parameter int                       PH_WIDTH  = PH_WIDTH_DEF,
    localparam int                      XW        = (GRID_W > 1) ? $clog2(GRID_W) : 1,
    localparam int                      YW        = (GRID_H > 1) ? $clog2(GRID_H) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          move,
    input  logic [PH_WIDTH-1:0] ph_drop,
    output logic                ant_l,
    output logic                ant_r,
    output logic                hit,
    output logic                escape,
    output logic [PH_WIDTH-1:0] ph_detected,
    output logic [XW-1:0]       pos_x,
    output logic [YW-1:0]       pos_y,
    output logic [1:0]          heading,
    output logic [15:0]         step_cnt,
    output logic                timeout,
    output logic                busy
);

    localparam int             NC        = GRID_W * GRID_H;
    localparam int             AW        = (NC > 1) ? $clog2(NC) : 1;
    localparam logic [XW-1:0]  SX        = XW'(START_X);
    localparam logic [YW-1:0]  SY        = YW'(START_Y);
    localparam logic [1:0]     SD        = 2'(START_DIR);
    localparam logic [XW-1:0]  EX        = XW'(EXIT_X);
    localparam logic [YW-1:0]  EY        = YW'(EXIT_Y);
    localparam logic [15:0]    STEP_LAST = 16'(MAX_STEPS - 1);
    localparam logic [15:0]    STEP_MAX  = 16'(MAX_STEPS);

    function automatic logic cell_blocked(input int x, input int y);
        logic [AW-1:0] idx;
        if (x < 0 || x >= GRID_W || y < 0 || y >= GRID_H) return 1'b1;
        idx = AW'(y * GRID_W + x);
        return MAZE[idx];
    endfunction

    function automatic logic nbr_blocked(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                         input logic [1:0] d);
        int nx;
        int ny;
        nx = int'(x);
        ny = int'(y);
        case (d)
            DIR_N:   ny = ny - 1;
            DIR_E:   nx = nx + 1;
            DIR_S:   ny = ny + 1;
            default: nx = nx - 1;
        endcase
        return cell_blocked(nx, ny);
    endfunction

    state_e          r_state, w_state_n;
    logic [XW-1:0]   r_x, w_nx;
    logic [YW-1:0]   r_y, w_ny;
    logic [1:0]      r_dir, w_ndir;
    logic            r_hit;
    logic [15:0]     r_step;
    logic            w_fwd_blk, w_at_exit, w_to_exit, w_restart, w_we;
    logic [AW-1:0]   w_addr;

    always_comb begin
        w_nx      = r_x;
        w_ny      = r_y;
        w_ndir    = r_dir;
        w_fwd_blk = nbr_blocked(r_x, r_y, r_dir);
        case (move)
            MV_RIGHT: w_ndir = r_dir + 2'd1;
            MV_LEFT:  w_ndir = r_dir - 2'd1;
            MV_FORWARD: begin
                if (!w_fwd_blk) begin
                    case (r_dir)
                        DIR_N:   w_ny = r_y - YW'(1);
                        DIR_E:   w_nx = r_x + XW'(1);
                        DIR_S:   w_ny = r_y + YW'(1);
                        default: w_nx = r_x - XW'(1);
                    endcase
                end
            end
            default: ;
        endcase
    end

    // Sitting on the exit is only possible when START is the exit; that run ends at once.
    assign w_at_exit = (r_x == EX) && (r_y == EY);
    assign w_to_exit = w_at_exit || ((w_nx == EX) && (w_ny == EY));
    assign w_restart = ((r_state == ST_DONE) || (r_state == ST_TMO)) && start;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_n = ST_RUN;
            ST_RUN: begin
                if (w_to_exit)                w_state_n = ST_DONE;
                else if (r_step == STEP_LAST) w_state_n = ST_TMO;
            end
            default: if (start) w_state_n = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x    <= SX;
            r_y    <= SY;
            r_dir  <= SD;
            r_hit  <= 1'b0;
            r_step <= '0;
        end else begin
            r_hit <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_x   <= SX;
                    r_y   <= SY;
                    r_dir <= SD;
                end
                ST_RUN: begin
                    if (r_step != STEP_MAX) r_step <= r_step + 16'd1;
                    if (!w_at_exit) begin
                        r_x   <= w_nx;
                        r_y   <= w_ny;
                        r_dir <= w_ndir;
                        r_hit <= (move == MV_FORWARD) && w_fwd_blk;
                    end
                end
                default: begin
                    if (start) begin
                        r_x    <= SX;
                        r_y    <= SY;
                        r_dir  <= SD;
                        r_step <= '0;
                    end
                end
            endcase
        end
    end

    // Deposits use the registered (pre-move) cell, so a drop lands on the cell being left.
    assign w_addr = AW'(r_y) * AW'(GRID_W) + AW'(r_x);
    assign w_we   = (r_state == ST_RUN) && (ph_drop != '0);

    ant_ph_map #(
        .CELLS (NC),
        .AW    (AW),
        .PW    (PH_WIDTH)
    ) u_ph_map (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_restart),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_drop  (ph_drop),
        .o_level (ph_detected)
    );

    assign ant_l    = nbr_blocked(r_x, r_y, r_dir - 2'd1);
    assign ant_r    = nbr_blocked(r_x, r_y, r_dir + 2'd1);
    assign hit      = r_hit;
    assign escape   = (r_state == ST_DONE);
    assign timeout  = (r_state == ST_TMO);
    assign busy     = (r_state == ST_RUN);
    assign pos_x    = r_x;
    assign pos_y    = r_y;
    assign heading  = r_dir;
    assign step_cnt = r_step;

endmodule

// File: tb/tb_ant_arena.sv
// Bench for ant_arena: four parameterisations share stimulus; each scenario checks one of them.
module tb_ant_arena;
    import ant_pkg::*;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
        logic [1:0] d;
        logic       h;
        logic [1:0] p;
    } pose_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] move = 2'b00;
    logic [1:0] ph_drop = 2'b00;

    logic        al [4], ar [4], hit [4], esc [4], tmo [4], busy [4];
    logic [2:0]  px [4], py [4];
    logic [1:0]  hd [4], ph [4];
    logic [15:0] cnt [4];

    int nerr = 0;
    int nchk = 0;
    int sel  = 0;
    pose_t sb[$];

    always #5 clk = ~clk;

    // 0: defaults, 1: wall at (1,0), 2: exit at (2,0), 3: MAX_STEPS=5
    for (genvar g = 0; g < 4; g++) begin : g_dut
        ant_arena #(
            .MAZE      (g == 1 ? 64'h2 : 64'h0),
            .EXIT_X    (g == 2 ? 2 : 7),
            .EXIT_Y    (g == 2 ? 0 : 7),
            .MAX_STEPS (g == 3 ? 5 : 1023)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start),
            .move        (move),
            .ph_drop     (ph_drop),
            .ant_l       (al[g]),
            .ant_r       (ar[g]),
            .hit         (hit[g]),
            .escape      (esc[g]),
            .ph_detected (ph[g]),
            .pos_x       (px[g]),
            .pos_y       (py[g]),
            .heading     (hd[g]),
            .step_cnt    (cnt[g]),
            .timeout     (tmo[g]),
            .busy        (busy[g])
        );
    end

    function automatic pose_t P(input int x, input int y, input int d, input int h, input int p);
        pose_t r;
        r.x = 3'(x); r.y = 3'(y); r.d = 2'(d); r.h = 1'(h); r.p = 2'(p);
        return r;
    endfunction

    function automatic pose_t now_pose();
        return P(int'(px[sel]), int'(py[sel]), int'(hd[sel]), int'(hit[sel]), int'(ph[sel]));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [1:0] mv, input logic [1:0] dr);
        move = mv; ph_drop = dr;
        tick();
        move = MV_HALT; ph_drop = 2'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        sel = 0;
        do_reset();
        nchk++;
        if ({now_pose(), esc[0], tmo[0], busy[0], cnt[0]} !== {P(0,0,1,0,0), 3'b000, 16'd0}) begin
            nerr++;
            $display("FAIL reset_state: got %p esc=%b tmo=%b busy=%b cnt=%0d want pose (0,0) E, all flags 0, cnt 0",
                     now_pose(), esc[0], tmo[0], busy[0], cnt[0]);
        end
        nchk++;
        if ({al[0], ar[0]} !== 2'b10) begin
            nerr++;
            $display("FAIL reset_sensors: got l=%b r=%b want l=1 r=0", al[0], ar[0]);
        end
    endtask

    task automatic test_turns();
        logic [1:0] dirs [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
        pose_t e;
        pulse_start();
        nchk++;
        if (busy[0] !== 1'b1) begin
            nerr++;
            $display("FAIL start_busy: got %b want 1", busy[0]);
        end
        for (int i = 0; i < 4; i++) sb.push_back(P(0, 0, int'(dirs[i]), 0, 0));
        for (int i = 0; i < 4; i++) begin
            go(MV_RIGHT, 2'd0);
            e = sb.pop_front();
            nchk++;
            if (now_pose() !== e) begin
                nerr++;
                $display("FAIL turn%0d: got %p want %p", i, now_pose(), e);
            end
        end
    endtask

    task automatic test_forward_edge();
        logic [1:0] mv [10];
        pose_t e;
        for (int i = 0; i < 7; i++) begin
            mv[i] = MV_FORWARD;
            sb.push_back(P(i + 1, 0, 1, 0, 0));
        end
        mv[7] = MV_FORWARD; sb.push_back(P(7, 0, 1, 1, 0));
        mv[8] = MV_FORWARD; sb.push_back(P(7, 0, 1, 1, 0));
        mv[9] = MV_HALT;    sb.push_back(P(7, 0, 1, 0, 0));
        for (int i = 0; i < 10; i++) begin
            go(mv[i], 2'd0);
            e = sb.pop_front();
            nchk++;
            if (now_pose() !== e) begin
                nerr++;
                $display("FAIL fwd%0d: got %p want %p", i, now_pose(), e);
            end
        end
        nchk++;
        if (cnt[0] !== 16'd14) begin
            nerr++;
            $display("FAIL step_cnt_run: got %0d want 14", cnt[0]);
        end
    endtask

    task automatic test_pheromone();
        logic [1:0] mv [7] = '{MV_HALT, MV_HALT, MV_HALT, MV_FORWARD, MV_LEFT, MV_LEFT, MV_FORWARD};
        logic [1:0] dr [7] = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
        pose_t e;
        sel = 0;
        do_reset();
        pulse_start();
        sb.push_back(P(0, 0, 1, 0, 2));
        sb.push_back(P(0, 0, 1, 0, 3));
        sb.push_back(P(0, 0, 1, 0, 3));
        sb.push_back(P(1, 0, 1, 0, 0));
        sb.push_back(P(1, 0, 0, 0, 0));
        sb.push_back(P(1, 0, 3, 0, 0));
        sb.push_back(P(0, 0, 3, 0, 3));
        for (int i = 0; i < 7; i++) begin
            go(mv[i], dr[i]);
            e = sb.pop_front();
            nchk++;
            if (now_pose() !== e) begin
                nerr++;
                $display("FAIL ph%0d: got %p want %p", i, now_pose(), e);
            end
        end
    endtask

    task automatic test_wall();
        pose_t e;
        sel = 1;
        do_reset();
        pulse_start();
        nchk++;
        if ({al[1], ar[1]} !== 2'b10) begin
            nerr++;
            $display("FAIL wall_sense_e: got l=%b r=%b want l=1 r=0", al[1], ar[1]);
        end
        sb.push_back(P(0, 0, 1, 1, 0));
        go(MV_FORWARD, 2'd0);
        e = sb.pop_front();
        nchk++;
        if (now_pose() !== e) begin
            nerr++;
            $display("FAIL wall_hit: got %p want %p", now_pose(), e);
        end
        sb.push_back(P(0, 0, 2, 0, 0));
        go(MV_RIGHT, 2'd0);
        e = sb.pop_front();
        nchk++;
        if (now_pose() !== e) begin
            nerr++;
            $display("FAIL wall_turn: got %p want %p", now_pose(), e);
        end
        nchk++;
        if ({al[1], ar[1]} !== 2'b11) begin
            nerr++;
            $display("FAIL wall_sense_s: got l=%b r=%b want l=1 r=1", al[1], ar[1]);
        end
    endtask

    task automatic test_escape();
        logic [1:0] mv [5] = '{MV_HALT, MV_FORWARD, MV_FORWARD, MV_FORWARD, MV_RIGHT};
        logic [1:0] dr [5] = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd3};
        pose_t e;
        sel = 2;
        do_reset();
        pulse_start();
        sb.push_back(P(0, 0, 1, 0, 2));
        sb.push_back(P(1, 0, 1, 0, 0));
        sb.push_back(P(2, 0, 1, 0, 0));
        sb.push_back(P(2, 0, 1, 0, 0));
        sb.push_back(P(2, 0, 1, 0, 0));
        for (int i = 0; i < 5; i++) begin
            go(mv[i], dr[i]);
            e = sb.pop_front();
            nchk++;
            if (now_pose() !== e) begin
                nerr++;
                $display("FAIL esc%0d: got %p want %p", i, now_pose(), e);
            end
            if (i == 2) begin
                nchk++;
                if ({esc[2], busy[2]} !== 2'b10) begin
                    nerr++;
                    $display("FAIL escape_flag: got esc=%b busy=%b want esc=1 busy=0", esc[2], busy[2]);
                end
            end
        end
        sb.push_back(P(0, 0, 1, 0, 0));
        pulse_start();
        e = sb.pop_front();
        nchk++;
        if (now_pose() !== e) begin
            nerr++;
            $display("FAIL restart_pose: got %p want %p", now_pose(), e);
        end
        nchk++;
        if ({esc[2], busy[2], cnt[2]} !== {2'b01, 16'd0}) begin
            nerr++;
            $display("FAIL restart_state: got esc=%b busy=%b cnt=%0d want esc=0 busy=1 cnt=0",
                     esc[2], busy[2], cnt[2]);
        end
    endtask

    task automatic test_timeout();
        sel = 3;
        do_reset();
        pulse_start();
        for (int i = 1; i <= 6; i++) begin
            go(MV_HALT, 2'd0);
            nchk++;
            if (i < 5) begin
                if ({tmo[3], busy[3], cnt[3]} !== {2'b01, 16'(i)}) begin
                    nerr++;
                    $display("FAIL tmo_run%0d: got tmo=%b busy=%b cnt=%0d want tmo=0 busy=1 cnt=%0d",
                             i, tmo[3], busy[3], cnt[3], i);
                end
            end else if ({tmo[3], busy[3], cnt[3]} !== {2'b10, 16'd5}) begin
                nerr++;
                $display("FAIL tmo_hit%0d: got tmo=%b busy=%b cnt=%0d want tmo=1 busy=0 cnt=5",
                         i, tmo[3], busy[3], cnt[3]);
            end
        end
        pulse_start();
        go(MV_HALT, 2'd1);
        go(MV_RIGHT, 2'd0);
        nchk++;
        if ({busy[3], cnt[3], hd[3]} !== {1'b1, 16'd2, 2'd2}) begin
            nerr++;
            $display("FAIL tmo_restart: got busy=%b cnt=%0d hd=%0d want busy=1 cnt=2 hd=2",
                     busy[3], cnt[3], hd[3]);
        end
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        nchk++;
        if ({now_pose(), esc[3], tmo[3], busy[3], cnt[3]} !== {P(0,0,1,0,0), 3'b000, 16'd0}) begin
            nerr++;
            $display("FAIL midrun_reset: got %p esc=%b tmo=%b busy=%b cnt=%0d want reset values",
                     now_pose(), esc[3], tmo[3], busy[3], cnt[3]);
        end
        tick();
        nchk++;
        if ({busy[3], cnt[3]} !== {1'b0, 16'd0}) begin
            nerr++;
            $display("FAIL reset_over_start: got busy=%b cnt=%0d want busy=0 cnt=0", busy[3], cnt[3]);
        end
    endtask

    initial begin
        test_reset();
        test_turns();
        test_forward_edge();
        test_pheromone();
        test_wall();
        test_escape();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
